// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity check helper.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 8;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // High when the received parity bit disagrees with the selected parity sense.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return (((^data) ^ pbit) != odd);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling prescaler: one tick every baud_div+1 clocks, restartable via clear.
// Shared by the UART receiver and transmitter.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_r;
    logic             at_end_s;

    assign at_end_s = (count_r == baud_div);
    // A clear restarts the period, so the tick is suppressed in that cycle.
    assign tick     = at_end_s && !clear;

    // Prescaler count, wrapping after baud_div and restarted by clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {DIV_W{1'b0}};
        end else if (clear || at_end_s) begin
            count_r <= {DIV_W{1'b0}};
        end else begin
            count_r <= count_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive front end: synchronises rx, finds start bits with 16x
// oversampling, deserialises 8N1/8P1 frames and writes good bytes to the FIFO.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rx_fifo_full,
    output logic             rx_fifo_wr_en,
    output logic [7:0]       rx_fifo_data,
    output logic             rx_busy,
    output logic             framing_error,
    output logic             parity_error,
    output logic             overrun_error
);

    import uart_pkg::*;

    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] START_TICK = 4'(START_SAMPLE - 1);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    logic       sync1_r, rx_sync_r, rx_s;
    rx_state_t  state_r, state_next_s;
    logic [3:0] tick_cnt_r, tick_cnt_next_s;
    logic [2:0] bit_cnt_r, bit_cnt_next_s;
    logic [7:0] shift_r, shift_next_s;
    logic       perr_r, perr_next_s;
    logic       wr_next_s, fe_next_s, pe_next_s, ov_next_s;
    logic       clear_s, tick_s, sample_s;
    logic       busy_r, wr_r, fe_r, pe_r, ov_r;
    logic [7:0] data_r;

    assign rx_s     = rx_sync_r;
    assign clear_s  = (state_r == ST_IDLE) && !rx_s;
    assign sample_s = tick_s && (tick_cnt_r == LAST_TICK);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_s),
        .baud_div (baud_div),
        .tick     (tick_s)
    );

    // Two-flop synchroniser on the asynchronous line, idling high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            sync1_r   <= rx;
            rx_sync_r <= sync1_r;
        end
    end

    // Frame sequencing, data capture and selection of the single STOP outcome.
    always_comb begin
        state_next_s = state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s = shift_r;
        perr_next_s = perr_r;
        wr_next_s = 1'b0;
        fe_next_s = 1'b0;
        pe_next_s = 1'b0;
        ov_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next_s = ST_START;
                    perr_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_r == START_TICK)) begin
                    state_next_s   = rx_s ? ST_IDLE : ST_DATA;
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_next_s   = {rx_s, shift_r[7:1]};
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_next_s = parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    perr_next_s  = parity_mismatch(shift_r, rx_s, parity_odd);
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    if (!rx_s) begin
                        fe_next_s    = 1'b1;
                        state_next_s = ST_BREAK;
                    end else if (perr_r) begin
                        pe_next_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (rx_fifo_full) begin
                        ov_next_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        wr_next_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // Hold here until the line recovers so a stuck-low line cannot retrigger.
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (state_next_s != state_r) begin
            tick_cnt_next_s = 4'd0;
        end else if (tick_s) begin
            tick_cnt_next_s = tick_cnt_r + 4'd1;
        end else begin
            tick_cnt_next_s = tick_cnt_r;
        end
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            perr_r     <= 1'b0;
            busy_r     <= 1'b0;
            wr_r       <= 1'b0;
            fe_r       <= 1'b0;
            pe_r       <= 1'b0;
            ov_r       <= 1'b0;
            data_r     <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            tick_cnt_r <= tick_cnt_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            perr_r     <= perr_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            wr_r       <= wr_next_s;
            fe_r       <= fe_next_s;
            pe_r       <= pe_next_s;
            ov_r       <= ov_next_s;
            data_r     <= wr_next_s ? shift_r : data_r;
        end
    end

    assign rx_fifo_wr_en = wr_r;
    assign rx_fifo_data  = data_r;
    assign rx_busy       = busy_r;
    assign framing_error = fe_r;
    assign parity_error  = pe_r;
    assign overrun_error = ov_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: good byte with exact latency,
// glitch, framing/break, parity, overrun, mid-frame reset and back-to-back frames.
module tb_uart_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        rx_fifo_full;
    logic        rx_fifo_wr_en;
    logic [7:0]  rx_fifo_data;
    logic        rx_busy;
    logic        framing_error;
    logic        parity_error;
    logic        overrun_error;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int wr_cyc     = 0;
    int wr_cnt     = 0;
    int fe_cnt     = 0;
    int pe_cnt     = 0;
    int ov_cnt     = 0;
    logic [7:0] wr_log[$];

    uart_rx dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .baud_div      (baud_div),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_wr_en (rx_fifo_wr_en),
        .rx_fifo_data  (rx_fifo_data),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun_error (overrun_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (rx_fifo_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
            wr_log.push_back(rx_fifo_data);
        end
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (parity_error)  pe_cnt <= pe_cnt + 1;
        if (overrun_error) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(16 * (int'(baud_div) + 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                              input logic stop_v, input int stop_len);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(pbit);
        for (int i = 0; i < stop_len; i++) drive_bit(stop_v);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; baud_div = 16'd0;
        parity_en = 1'b0; parity_odd = 1'b0; rx_fifo_full = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        check("reset_data", 32'(rx_fifo_data), 32'h00);
        check("reset_errs", 32'({framing_error, parity_error, overrun_error}), 32'd0);

        // Good 8N1 byte at baud_div=0, exact write latency.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1);
        idle(4);
        check("good_wr_cnt", 32'(wr_cnt), 32'd1);
        check("good_data", 32'(wr_log[0]), 32'hA5);
        check("good_latency", 32'(wr_cyc - start_cyc), 32'd155);
        check("good_no_err", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // Glitch: 20 clocks low at baud_div=3 is shorter than half a bit.
        baud_div = 16'd3;
        rx = 1'b0;
        idle(10);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        idle(10);
        rx = 1'b1;
        idle(60);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_no_wr", 32'(wr_cnt), 32'd1);
        check("glitch_no_err", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // Framing error followed by a held-low break, then recovery.
        baud_div = 16'd1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 40);
        check("frame_fe_cnt", 32'(fe_cnt), 32'd1);
        check("frame_no_wr", 32'(wr_cnt), 32'd1);
        check("frame_break_busy", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        idle(6);
        check("frame_break_exit", 32'(rx_busy), 32'd0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1);
        idle(4);
        check("after_break_wr", 32'(wr_cnt), 32'd2);
        check("after_break_data", 32'(wr_log[1]), 32'h11);
        check("after_break_fe", 32'(fe_cnt), 32'd1);

        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1);
        idle(4);
        check("par_ok_wr", 32'(wr_cnt), 32'd3);
        check("par_ok_data", 32'(wr_log[2]), 32'h07);
        check("par_ok_pe", 32'(pe_cnt), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1);
        idle(4);
        check("par_bad_pe", 32'(pe_cnt), 32'd1);
        check("par_bad_no_wr", 32'(wr_cnt), 32'd3);

        // Overrun while the FIFO is full, then a normal write.
        parity_en = 1'b0;
        rx_fifo_full = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1);
        idle(4);
        check("ovr_cnt", 32'(ov_cnt), 32'd1);
        check("ovr_no_wr", 32'(wr_cnt), 32'd3);
        rx_fifo_full = 1'b0;
        send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1);
        idle(4);
        check("ovr_after_wr", 32'(wr_cnt), 32'd4);
        check("ovr_after_data", 32'(wr_log[3]), 32'h56);
        check("ovr_after_ov", 32'(ov_cnt), 32'd1);

        // Reset during data bit 3 of 0xFF.
        baud_div = 16'd0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        idle(8);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst_mid_busy", 32'(rx_busy), 32'd0);
        check("rst_mid_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        check("rst_mid_data", 32'(rx_fifo_data), 32'h00);
        check("rst_mid_errs", 32'({framing_error, parity_error, overrun_error}), 32'd0);
        idle(200);
        check("rst_mid_no_wr", 32'(wr_cnt), 32'd4);
        check("rst_mid_no_err", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd3);

        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1);
        idle(4);
        check("b2b_wr_cnt", 32'(wr_cnt), 32'd6);
        check("b2b_first", 32'(wr_log[4]), 32'h01);
        check("b2b_second", 32'(wr_log[5]), 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end of the UART. It synchronises the asynchronous `rx` line, detects start bits with 16x oversampling and mid-bit sampling, and deserialises 8 data bits with optional parity. It presents each good byte to the downstream receive FIFO as a one-cycle write. It sits directly upstream of the receive FIFO and drives that FIFO's write-enable and write-data inputs.

## Interface
Parameters:
- `OVERSAMPLE`, 16: ticks per bit. Fixed; other values are not supported.
- `DIV_W`, 16: width of `baud_div`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `baud_div`  in  DIV_W  tick period minus one, in clocks. Changed only while `rx_busy`=0.
- `parity_en`  in  1  1 = frame carries a parity bit after the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `rx_fifo_full`  in  1  full flag from the downstream FIFO.
- `rx_fifo_wr_en`  out  1  one-cycle write strobe to the FIFO.
- `rx_fifo_data`  out  8  received byte; valid while `rx_fifo_wr_en`=1, held otherwise.
- `rx_busy`  out  1  high in every state except IDLE.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_error`  out  1  one-cycle pulse: parity mismatch.
- `overrun_error`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- **Synchroniser:** 2-flop, both flops reset to 1. `rx_s` is its output. All logic below uses `rx_s`.
- **Prescaler:** counts 0..`baud_div`. `tick` is high when the count equals `baud_div`, then the count wraps to 0. The count is forced to 0 in the IDLE cycle that sees `rx_s`=0.
- **Tick counter:** 4 bits. Cleared on every state transition.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE:** if `rx_s`=0, go to START.
- **START:** on the 8th tick, sample `rx_s`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no outputs.
- **DATA:** on every 16th tick, sample one bit LSB first. The shift register shifts right and takes the new bit into [7]. After bit 7, go to PARITY if `parity_en`=1, else go to STOP.
- **PARITY:** on the 16th tick, sample the parity bit. Even parity requires XOR(data, pbit)=0; odd parity requires it to be 1. A mismatch sets an internal `perr` flag.
- **STOP:** on the 16th tick, sample `rx_s`, then take exactly one of these actions:
  - `rx_s`=0: pulse `framing_error`, do not write, go to BREAK.
  - `rx_s`=1 and `perr`=1: pulse `parity_error`, do not write, go to IDLE.
  - `rx_s`=1, `perr`=0, `rx_fifo_full`=1: pulse `overrun_error`, do not write, go to IDLE.
  - Otherwise: pulse `rx_fifo_wr_en` with the byte on `rx_fifo_data`, go to IDLE.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **Error priority:** at most one of the four STOP pulses is asserted per frame, in the priority order listed above.
- **`perr` clearing:** `perr` is cleared on entry to START.
- **`rx_fifo_full` sampling:** `rx_fifo_full` is sampled only on the STOP-sample tick.

## Timing
- **Reset values:** state IDLE; `rx_busy`=0; `rx_fifo_wr_en`=0; `rx_fifo_data`=8'h00; all error outputs 0; prescaler, tick counter, shift register and `perr` all 0.
- **Reset mid-frame:** the frame is abandoned with no write and no error pulse. Reception resumes from IDLE on the next falling edge.
- **Synchroniser latency:** 2 clocks from `rx` to `rx_s`.
- **Tick times:** let E be the IDLE cycle in which `rx_s`=0 is seen. The nth tick after E falls at cycle E+n(`baud_div`+1).
- **Sample points:**
  - start bit: tick 8
  - data bit k: tick 24+16k
  - parity bit (if enabled): tick 152
  - stop bit: tick 152 without parity, tick 168 with parity
- **Output latency:** all STOP pulses (write or error) are registered and are high in the cycle after the stop-sample tick. With `baud_div`=0 and no parity, `rx_fifo_wr_en` is high at cycle E+153.
- **Back-to-back frames:** `rx_busy` deasserts on the IDLE return, so a start edge arriving on the following cycle is accepted.

## Structure
- **`uart_pkg`:** shared package holding the state enum `rx_state_t`, `OVERSAMPLE`=16, `START_SAMPLE`=8 and `DATA_BITS`=8.
- **`uart_baud_gen`:** sub-module containing the prescaler, with ports `clock`, `reset`, `clear`, `baud_div` and `tick`. It is reused by the transmitter.
- **Synchroniser:** stays inline.

## Test plan
- **Good byte:** `baud_div`=0, `parity_en`=0, send 8N1 byte 0xA5 -> a single `rx_fifo_wr_en` pulse at E+153 with `rx_fifo_data`=0xA5, and no error pulses.
- **Glitch rejection:** `baud_div`=3, drive `rx` low for 20 clocks, then high -> state returns to IDLE; no write and no error.
- **Framing error:** send 0x3C with the stop bit held 0 for 40 bit-times -> one `framing_error` pulse, no write, BREAK until `rx` rises. A subsequent 0x11 is then received correctly.
- **Parity:** `parity_en`=1, `parity_odd`=0, send 0x07 with pbit=1 -> written as 0x07. Send 0x07 with pbit=0 -> `parity_error` pulse and no write.
- **Overrun:** hold `rx_fifo_full`=1 and send 0x55 -> `overrun_error` pulse and no write. Deassert `rx_fifo_full` and send 0x56 -> written as 0x56.
- **Reset and back-to-back:** assert `reset` during data bit 3 of 0xFF -> no write, all outputs at reset values. Then send 0x01 and 0x80 back-to-back -> two writes, 0x01 then 0x80.
